acc_result_ci_reader: RTL and testbench

- CPU-facing read end of the accumulator result path.
- PE array pushes finished 32-bit accumulation results over a valid/ready stream into an internal FIFO.
- Nios II drains the FIFO through a multi-cycle custom instruction (start/done) with blocking pop, peek, status and flush opcodes.
- Complements the push-side custom instruction: that side writes from the CPU; this block reads towards the CPU with proper flow control.

---
 rtl/acc_result_ci_reader.sv | 208 ++++++++++++++++++++
 tb/tb_acc_result_ci_reader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_result_ci_reader.sv
// rtl/acc_result_ci_reader.sv - CPU-side custom-instruction reader draining the accumulator result FIFO
module acc_result_ci_reader #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result,
  input  logic        pe_valid,
  input  logic [31:0] pe_data,
  output logic        pe_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = 16;

  localparam logic [1:0] OP_POP    = 2'd0;
  localparam logic [1:0] OP_PEEK   = 2'd1;
  localparam logic [1:0] OP_STATUS = 2'd2;
  localparam logic [1:0] OP_FLUSH  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      op_q;
  logic [1:0]      op_cur;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            err;
  logic [TW-1:0]   tcnt;
  logic [31:0]     result_q;
  logic [31:0]     load_val;
  logic [31:0]     mem [DEPTH];

  logic            is_fetch;
  logic            do_load;
  logic            do_wait_enter;
  logic            do_timeout;
  logic            do_pop;
  logic            do_flush;
  logic            do_push;

  // The operand bus is part of the custom-instruction interface but carries nothing here.
  logic            unused_dataa;
  assign unused_dataa = ^dataa;

  // Ready depends only on registered occupancy and the enable, never on pe_valid.
  assign pe_ready = clk_en & (count != CW'(DEPTH));
  assign result   = result_q;

  // Decode what this cycle does: load a response, start waiting, time out, pop, flush, push.
  always_comb begin
    op_cur        = (state == S_IDLE) ? n : op_q;
    is_fetch      = (op_cur == OP_POP) || (op_cur == OP_PEEK);
    do_load       = 1'b0;
    do_wait_enter = 1'b0;
    do_timeout    = 1'b0;
    if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_fetch && (count == '0)) begin
              do_wait_enter = 1'b1;
            end else begin
              do_load = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (count != '0) begin
            do_load = 1'b1;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            do_timeout = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
    do_pop   = do_load && (op_cur == OP_POP);
    do_flush = do_load && (op_cur == OP_FLUSH);
    // A word arriving in the same cycle as a flush is dropped with the rest of the queue.
    do_push  = pe_valid && pe_ready && !do_flush;
  end

  // Value captured into the result register when an opcode completes normally.
  always_comb begin
    load_val = 32'h0;
    case (op_cur)
      OP_POP, OP_PEEK: load_val = mem[rd_ptr];
      OP_STATUS:       load_val = {err, 15'b0, 16'(count)};
      default:         load_val = 32'h0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; everything holds while clk_en is low.
  always_comb begin
    state_nxt = state;
    if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (do_wait_enter) begin
            state_nxt = S_WAIT;
          end else if (do_load) begin
            state_nxt = S_RESP;
          end
        end
        S_WAIT: begin
          if (do_load || do_timeout) begin
            state_nxt = S_RESP;
          end
        end
        S_RESP:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: a single done pulse in RESP, suppressed while the core is frozen.
  always_comb begin
    done = 1'b0;
    if (clk_en && (state == S_RESP)) begin
      done = 1'b1;
    end
  end

  // Storage array; only written, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= pe_data;
    end
  end

  // Pointers, occupancy, error flag, opcode latch, timeout counter and result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      err      <= 1'b0;
      op_q     <= OP_POP;
      tcnt     <= '0;
      result_q <= 32'h0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      if (do_flush) begin
        rd_ptr <= wr_ptr;
      end else if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      if (do_flush) begin
        count <= '0;
      end else if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end

      if (do_flush) begin
        err <= 1'b0;
      end else if (do_timeout) begin
        err <= 1'b1;
      end

      if (clk_en && (state == S_IDLE) && start) begin
        op_q <= n;
      end

      if (do_wait_enter) begin
        tcnt <= '0;
      end else if (clk_en && (state == S_WAIT) && !do_load && !do_timeout) begin
        tcnt <= tcnt + TW'(1);
      end

      if (do_load) begin
        result_q <= load_val;
      end else if (do_timeout) begin
        result_q <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_acc_result_ci_reader.sv
// tb/tb_acc_result_ci_reader.sv - directed self-checking bench for acc_result_ci_reader
module tb_acc_result_ci_reader;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;

  localparam logic [1:0] OP_POP    = 2'd0;
  localparam logic [1:0] OP_PEEK   = 2'd1;
  localparam logic [1:0] OP_STATUS = 2'd2;
  localparam logic [1:0] OP_FLUSH  = 2'd3;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        clk_en   = 1'b1;
  logic        start    = 1'b0;
  logic [1:0]  n        = 2'd0;
  logic [31:0] dataa    = 32'h0;
  logic        done;
  logic [31:0] result;
  logic        pe_valid = 1'b0;
  logic [31:0] pe_data  = 32'h0;
  logic        pe_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_result_ci_reader #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .start    (start),
    .n        (n),
    .dataa    (dataa),
    .done     (done),
    .result   (result),
    .pe_valid (pe_valid),
    .pe_data  (pe_data),
    .pe_ready (pe_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op);
    @(negedge clk);
    start = 1'b1;
    n     = op;
    dataa = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d);
    @(negedge clk);
    pe_valid = 1'b1;
    pe_data  = d;
    @(posedge clk);
    #1;
    pe_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", result); end
    checks++; if (pe_ready !== 1'b1) begin errors++; $display("FAIL reset_pe_ready: got %b want 1", pe_ready); end
    @(negedge clk);
    reset = 1'b1;
    issue(OP_STATUS);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL reset_status_done: got %b want 1", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_status_result: got %h want 00000000", result); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done_one_cycle: got %b want 0", done); end
  endtask

  task automatic test_pop_order();
    logic [31:0] exp_v [3];
    exp_v = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) push_word(exp_v[i]);
    for (int i = 0; i < 3; i++) begin
      issue(OP_POP);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL pop_order_done[%0d]: got %b want 1", i, done); end
      checks++; if (result !== exp_v[i]) begin errors++; $display("FAIL pop_order_result[%0d]: got %h want %h", i, result, exp_v[i]); end
      step();
    end
    issue(OP_STATUS);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL pop_order_status: got %h want 00000000", result); end
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      pe_valid = 1'b1;
      pe_data  = 32'(i);
      checks++; if (pe_ready !== 1'b1) begin errors++; $display("FAIL full_ready_before[%0d]: got %b want 1", i, pe_ready); end
      @(posedge clk);
      #1;
    end
    pe_data = 32'h100;
    checks++; if (pe_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after16: got %b want 0", pe_ready); end
    step();
    step();
    checks++; if (pe_ready !== 1'b0) begin errors++; $display("FAIL full_ready_held: got %b want 0", pe_ready); end
    issue(OP_STATUS);
    checks++; if (result !== 32'h10) begin errors++; $display("FAIL full_status_count: got %h want 00000010", result); end
    step();
    issue(OP_POP);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_pop_done: got %b want 1", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL full_pop_result: got %h want 00000000", result); end
    checks++; if (pe_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", pe_ready); end
    step();
    pe_valid = 1'b0;
    checks++; if (pe_ready !== 1'b0) begin errors++; $display("FAIL full_held_word_accepted: got %b want 0", pe_ready); end
    for (int i = 1; i <= DEPTH; i++) begin
      logic [31:0] want;
      want = (i == DEPTH) ? 32'h100 : 32'(i);
      issue(OP_POP);
      checks++; if (result !== want) begin errors++; $display("FAIL full_drain[%0d]: got %h want %h", i, result, want); end
      step();
    end
    checks++; if (pe_ready !== 1'b1) begin errors++; $display("FAIL full_ready_drained: got %b want 1", pe_ready); end
  endtask

  task automatic test_blocked_pop();
    issue(OP_POP);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL blocked_done_T: got %b want 0", done); end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL blocked_wait[%0d]: got %b want 0", k, done); end
    end
    push_word(32'hABCD);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL blocked_push_edge: got %b want 0", done); end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL blocked_done: got %b want 1", done); end
    checks++; if (result !== 32'hABCD) begin errors++; $display("FAIL blocked_result: got %h want 0000abcd", result); end
    step();
    issue(OP_STATUS);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL blocked_status: got %h want 00000000", result); end
    step();
  endtask

  task automatic test_timeout();
    issue(OP_POP);
    for (int k = 1; k <= TIMEOUT; k++) begin
      logic want;
      step();
      want = (k == TIMEOUT);
      checks++; if (done !== want) begin errors++; $display("FAIL timeout_done[%0d]: got %b want %b", k, done, want); end
    end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL timeout_result: got %h want 00000000", result); end
    step();
    issue(OP_STATUS);
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL timeout_status_err: got %h want 80000000", result); end
    step();
    issue(OP_FLUSH);
    checks++; if (done !== 1'b1 || result !== 32'h0) begin errors++; $display("FAIL timeout_flush: got done=%b result=%h want done=1 result=00000000", done, result); end
    step();
    issue(OP_STATUS);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL timeout_status_cleared: got %h want 00000000", result); end
    step();
  endtask

  task automatic test_simultaneous();
    push_word(32'h77);
    @(negedge clk);
    start = 1'b1; n = OP_POP; pe_valid = 1'b1; pe_data = 32'h88;
    @(posedge clk);
    #1;
    start = 1'b0; pe_valid = 1'b0;
    checks++; if (result !== 32'h77) begin errors++; $display("FAIL sim_pop_old_head: got %h want 00000077", result); end
    step();
    issue(OP_STATUS);
    checks++; if (result !== 32'h1) begin errors++; $display("FAIL sim_pop_count: got %h want 00000001", result); end
    step();
    issue(OP_POP);
    checks++; if (result !== 32'h88) begin errors++; $display("FAIL sim_pop_new_word: got %h want 00000088", result); end
    step();
    push_word(32'h1);
    @(negedge clk);
    start = 1'b1; n = OP_FLUSH; pe_valid = 1'b1; pe_data = 32'h2;
    @(posedge clk);
    #1;
    start = 1'b0; pe_valid = 1'b0;
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL sim_flush_result: got %h want 00000000", result); end
    step();
    issue(OP_STATUS);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL sim_flush_count: got %h want 00000000", result); end
    step();
    push_word(32'h3);
    issue(OP_POP);
    checks++; if (result !== 32'h3) begin errors++; $display("FAIL sim_flush_push_discarded: got %h want 00000003", result); end
    step();
  endtask

  task automatic test_clk_en();
    push_word(32'h44);
    issue(OP_PEEK);
    clk_en   = 1'b0;
    pe_valid = 1'b1;
    pe_data  = 32'h99;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clken_done_forced: got %b want 0", done); end
    checks++; if (pe_ready !== 1'b0) begin errors++; $display("FAIL clken_pe_ready: got %b want 0", pe_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL clken_frozen[%0d]: got %b want 0", k, done); end
    end
    pe_valid = 1'b0;
    @(negedge clk);
    clk_en = 1'b1;
    #1;
    checks++; if (done !== 1'b1 || result !== 32'h44) begin errors++; $display("FAIL clken_resume: got done=%b result=%h want done=1 result=00000044", done, result); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clken_done_falls: got %b want 0", done); end
    checks++; if (result !== 32'h44) begin errors++; $display("FAIL clken_result_kept: got %h want 00000044", result); end
    issue(OP_STATUS);
    checks++; if (result !== 32'h1) begin errors++; $display("FAIL clken_status_count: got %h want 00000001", result); end
    step();
    issue(OP_FLUSH);
    step();
  endtask

  task automatic test_peek_push_and_reset();
    push_word(32'h9);
    @(negedge clk);
    start = 1'b1; n = OP_PEEK; pe_valid = 1'b1; pe_data = 32'h5;
    @(posedge clk);
    #1;
    start = 1'b0; pe_valid = 1'b0;
    checks++; if (done !== 1'b1 || result !== 32'h9) begin errors++; $display("FAIL peek_push_result: got done=%b result=%h want done=1 result=00000009", done, result); end
    step();
    issue(OP_STATUS);
    checks++; if (result !== 32'h2) begin errors++; $display("FAIL peek_push_count: got %h want 00000002", result); end
    step();
    issue(OP_POP);
    checks++; if (result !== 32'h9) begin errors++; $display("FAIL peek_pop_first: got %h want 00000009", result); end
    step();
    issue(OP_POP);
    checks++; if (result !== 32'h5) begin errors++; $display("FAIL peek_pop_second: got %h want 00000005", result); end
    step();
    issue(OP_POP);
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midwait_reset_done: got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midwait_reset_result: got %h want 00000000", result); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midwait_in_reset[%0d]: got %b want 0", k, done); end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < TIMEOUT + 2; k++) begin
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midwait_after_reset[%0d]: got %b want 0", k, done); end
    end
    issue(OP_STATUS);
    checks++; if (done !== 1'b1 || result !== 32'h0) begin errors++; $display("FAIL midwait_status: got done=%b result=%h want done=1 result=00000000", done, result); end
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pop_order();
    test_full();
    test_blocked_pop();
    test_timeout();
    test_simultaneous();
    test_clk_en();
    test_peek_push_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
